// File: rtl/pitch_sdram_bridge.sv
// pitch_sdram_bridge: bridges the pitch core's single-word request port onto
// the SDRAM controller's Avalon-MM pipelined slave. One transaction at a time,
// every output registered.
//
// Optional feature: define PITCH_BRIDGE_TIMEOUT_EN to bound the wait for read
// data to TIMEOUT_CYCLES cycles (read returns 0, sticky o_timeout set).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for req_read/req_write, request latched on entry to CMD
// CMD     | avm_read/avm_write asserted until waitrequest drops
// WAIT_RD | read accepted, waiting for readdatavalid
// DONE    | req_finished high for this single cycle
// RELEASE | waiting for the core to drop both request lines
module pitch_sdram_bridge #(
   parameter int ADDR_W         = 23,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                req_read,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_writedata,
   output logic [DATA_W-1:0]   req_readdata,
   output logic                req_finished,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_waitrequest,
   input  logic                avm_readdatavalid,
   output logic                o_timeout
);

   typedef enum logic [2:0] {IDLE, CMD, WAIT_RD, DONE, RELEASE} state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("pitch_sdram_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   state_t              state_q, state_nxt;
   logic                is_write_q, is_write_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [DATA_W-1:0]   wdata_nxt;
   logic [DATA_W-1:0]   readdata_nxt;
   logic                read_nxt, write_nxt, finished_nxt;

`ifdef PITCH_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_nxt;
   logic                timeout_q, timeout_nxt;

   assign o_timeout = timeout_q;
`else
   assign o_timeout = 1'b0;
`endif

   assign avm_byteenable = '1;

   // Next-state and next-output decode; every register holds unless a state acts.
   always_comb begin
      state_nxt    = state_q;
      is_write_nxt = is_write_q;
      addr_nxt     = avm_address;
      wdata_nxt    = avm_writedata;
      readdata_nxt = req_readdata;
      read_nxt     = avm_read;
      write_nxt    = avm_write;
      finished_nxt = 1'b0;
`ifdef PITCH_BRIDGE_TIMEOUT_EN
      cnt_nxt      = cnt_q;
      timeout_nxt  = timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_read || req_write) begin
               // write wins when both lines are high
               addr_nxt     = req_addr;
               wdata_nxt    = req_writedata;
               is_write_nxt = req_write;
               write_nxt    = req_write;
               read_nxt     = ~req_write;
               state_nxt    = CMD;
            end
         end
         CMD: begin
            if (!avm_waitrequest) begin
               read_nxt  = 1'b0;
               write_nxt = 1'b0;
               if (is_write_q) begin
                  finished_nxt = 1'b1;
                  state_nxt    = DONE;
               end else begin
`ifdef PITCH_BRIDGE_TIMEOUT_EN
                  cnt_nxt = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                  state_nxt = WAIT_RD;
               end
            end
         end
         WAIT_RD: begin
            if (avm_readdatavalid) begin
               readdata_nxt = avm_readdata;
               finished_nxt = 1'b1;
               state_nxt    = DONE;
            end
`ifdef PITCH_BRIDGE_TIMEOUT_EN
            else if (cnt_q == '0) begin
               readdata_nxt = '0;
               timeout_nxt  = 1'b1;
               finished_nxt = 1'b1;
               state_nxt    = DONE;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
`endif
         end
         DONE: begin
            state_nxt = RELEASE;
         end
         RELEASE: begin
            // a request still held from the finished transaction must not re-run
            if (!req_read && !req_write) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any command immediately.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q       <= IDLE;
         is_write_q    <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         req_readdata  <= '0;
         req_finished  <= 1'b0;
`ifdef PITCH_BRIDGE_TIMEOUT_EN
         cnt_q         <= '0;
         timeout_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_nxt;
         is_write_q    <= is_write_nxt;
         avm_address   <= addr_nxt;
         avm_writedata <= wdata_nxt;
         avm_read      <= read_nxt;
         avm_write     <= write_nxt;
         req_readdata  <= readdata_nxt;
         req_finished  <= finished_nxt;
`ifdef PITCH_BRIDGE_TIMEOUT_EN
         cnt_q         <= cnt_nxt;
         timeout_q     <= timeout_nxt;
`endif
      end
   end

endmodule
